bus_control_unit: RTL and testbench
===================================

// Module: bus_control_unit
// PURPOSE
//  Control FSM that drives the processor's shared 16-bit bus. It generates the one-hot
//  bus-source selects (ROut/GOut/DINOut) consumed by the bus multiplexer, and the matching
//  load enables (RIn/IRIn/AIn/GIn) for the register file, IR, A and G registers.
//  Sequences 9-bit instructions IIIXXXYYY (opcode, Rx, Ry) over 2-4 steps and pulses Done.
// PARAMETERS
//  NREG   8  number of general registers; select buses are NREG bits one-hot (fixed 8, 3-bit fields)
//  IR_W   9  instruction width: [8:6] opcode, [5:3] Rx, [2:0] Ry
// PORTS
//  Clock   in   1      rising-edge clock
//  Reset   in   1      synchronous, active-high; step counter -> T0
//  Run     in   1      start: sampled in T0
//  IR      in   IR_W   current instruction (IR register output, valid from T1)
//  ROut    out  NREG   one-hot bus source select, register Ry/Rx
//  GOut    out  1      bus source = G
//  DINOut  out  1      bus source = DIN
//  RIn     out  NREG   one-hot register load enable
//  IRIn    out  1      IR load enable (from DIN)
//  AIn     out  1      A load enable (from bus)
//  GIn     out  1      G load enable (A +/- bus)
//  AddSub  out  1      0 = add, 1 = subtract (valid with GIn)
//  Done    out  1      one-cycle pulse in final step of each instruction
//  GNZ     in   1      G != 0 flag (present only with CU_MVNZ_EN)
// BEHAVIOUR
//  - Registered 2-bit step counter Tstep: T0, T1, T2, T3. All outputs combinational from Tstep+IR+Run.
//  - Reset: Tstep <= T0 at next edge; while Reset=1 every output is forced 0. Reset mid-instruction
//    abandons it: no Done, no further writes.
//  - Default every cycle: all outputs 0.
//  - T0: if Run: IRIn=1, next T1; else stay T0.
//  - T1 decode (X=onehot(IR[5:3]), Y=onehot(IR[2:0])):
//     000 mv  Rx,Ry : ROut=Y, RIn=X, Done=1 -> T0
//     001 mvi Rx,#D : DINOut=1, RIn=X, Done=1 -> T0 (DIN holds immediate this cycle)
//     010 add Rx,Ry : ROut=X, AIn=1 -> T2
//     011 sub Rx,Ry : ROut=X, AIn=1 -> T2
//     other         : Done=1, no enables (NOP) -> T0
//  - T2 (add/sub): ROut=Y, GIn=1, AddSub=IR[6] -> T3
//  - T3 (add/sub): GOut=1, RIn=X, Done=1 -> T0
//  - Invariant: at most one of {ROut bits, GOut, DINOut} high per cycle; exactly one in every
//    cycle where any RIn/AIn/GIn is high (bus mux has priority DIN>G>R and undefined on zero).
//  - mv Rx,Rx legal (ROut=RIn=same bit). Run ignored outside T0. Back-to-back: Done cycle
//    returns to T0; next instruction starts when Run is seen in T0 (min 1 idle cycle).
//  - IR must be stable from T1 until the instruction's Done.
// CONFIGURATION
//  CU_MVNZ_EN defined: opcode 100 = mvnz Rx,Ry in T1: if GNZ: ROut=Y, RIn=X; always Done=1 -> T0.
//    GNZ port exists.
//  CU_MVNZ_EN undefined: no GNZ port; opcode 100 is a NOP (Done only).
// STRUCTURE
//  Package cu_pkg: opcode localparams (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_MVNZ), step enum
//  typedef (T0..T3), field slices (OPC_MSB/LSB, RX_MSB/LSB, RY_MSB/LSB).
//  One sub-module: dec3to8 (3-bit -> 8-bit one-hot, enable input), instantiated for X and Y.
// TESTING
//  1 Reset=1 two cycles, Run=1 -> all outputs 0, Tstep stays T0; release -> IRIn=1 next cycle.
//  2 Run, IR=9'b000_010_101 (mv R2,R5) -> T1: ROut=8'h20, RIn=8'h04, Done=1; then T0.
//  3 IR=9'b001_111_000 (mvi R7) -> T1: DINOut=1, RIn=8'h80, Done=1; ROut=0, GOut=0.
//  4 IR=9'b011_001_011 (sub R1,R3) -> T1 ROut=02,AIn; T2 ROut=08,GIn,AddSub=1; T3 GOut,RIn=02,Done.
//  5 add in progress, Reset=1 in T2 -> next cycle T0, no T3 RIn/Done, all outputs 0 during Reset.
//  6 IR=9'b100_000_001 with GNZ=0 then GNZ=1 -> Done only / ROut=02,RIn=01 (CU_MVNZ_EN);
//    NOP both times when undefined. Bench checks one-hot invariant every cycle.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the bus control unit: instruction field positions,
// opcode encodings and the step-counter state type.
package cu_pkg;

  localparam int NREG = 8;
  localparam int IR_W = 9;

  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 6;
  localparam int RX_MSB  = 5;
  localparam int RX_LSB  = 3;
  localparam int RY_MSB  = 2;
  localparam int RY_LSB  = 0;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

endpackage

// File: rtl/dec3to8.sv
// 3-bit to 8-bit one-hot decoder with enable; used to turn the Rx and Ry
// instruction fields into register select / load-enable vectors.
module dec3to8
  import cu_pkg::*;
(
  input  logic [2:0]      sel,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/bus_control_unit.sv
// Step-sequenced control FSM for the shared processor bus: selects the bus
// source and raises register load enables. Optional mvnz opcode: CU_MVNZ_EN.
module bus_control_unit
  import cu_pkg::*;
(
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Run,
  input  logic [IR_W-1:0] IR,
`ifdef CU_MVNZ_EN
  input  logic            GNZ,
`endif
  output logic [NREG-1:0] ROut,
  output logic            GOut,
  output logic            DINOut,
  output logic [NREG-1:0] RIn,
  output logic            IRIn,
  output logic            AIn,
  output logic            GIn,
  output logic            AddSub,
  output logic            Done
);

  step_t            tStep;
  step_t            nextStep;
  logic [2:0]       opcode;
  logic [NREG-1:0]  xOneHot;
  logic [NREG-1:0]  yOneHot;

  assign opcode = IR[OPC_MSB:OPC_LSB];

  // Decoders are held off during reset so no select can leak onto the bus
  dec3to8 xDec (
    .sel    (IR[RX_MSB:RX_LSB]),
    .en     (~Reset),
    .onehot (xOneHot)
  );

  dec3to8 yDec (
    .sel    (IR[RY_MSB:RY_LSB]),
    .en     (~Reset),
    .onehot (yOneHot)
  );

  always_ff @(posedge Clock) begin
    if (Reset) tStep <= T0;
    else       tStep <= nextStep;
  end

  // T2/T3 are only reachable from add/sub, so they need no opcode check
  always_comb begin
    nextStep = tStep;
    ROut     = '0;
    GOut     = 1'b0;
    DINOut   = 1'b0;
    RIn      = '0;
    IRIn     = 1'b0;
    AIn      = 1'b0;
    GIn      = 1'b0;
    AddSub   = 1'b0;
    Done     = 1'b0;
    if (!Reset) begin
      case (tStep)
        T0: begin
          if (Run) begin
            IRIn     = 1'b1;
            nextStep = T1;
          end
        end
        T1: begin
          nextStep = T0;
          case (opcode)
            OP_MV: begin
              ROut = yOneHot;
              RIn  = xOneHot;
              Done = 1'b1;
            end
            OP_MVI: begin
              DINOut = 1'b1;
              RIn    = xOneHot;
              Done   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ROut     = xOneHot;
              AIn      = 1'b1;
              nextStep = T2;
            end
`ifdef CU_MVNZ_EN
            OP_MVNZ: begin
              if (GNZ) begin
                ROut = yOneHot;
                RIn  = xOneHot;
              end
              Done = 1'b1;
            end
`endif
            default: Done = 1'b1;
          endcase
        end
        T2: begin
          ROut     = yOneHot;
          GIn      = 1'b1;
          AddSub   = IR[OPC_LSB];
          nextStep = T3;
        end
        T3: begin
          GOut     = 1'b1;
          RIn      = xOneHot;
          Done     = 1'b1;
          nextStep = T0;
        end
        default: nextStep = T0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_control_unit.sv
// Self-checking bench for bus_control_unit: directed cycle table followed by
// randomized instruction streams checked against a per-instruction model.
module tb_bus_control_unit;

  typedef struct packed {
    logic [7:0] rout;
    logic       gout;
    logic       dinout;
    logic [7:0] rin;
    logic       irin;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic       done;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic       run;
    logic [8:0] ir;
    logic       gnz;
    out_t       exp;
  } vec_t;

  logic       clock;
  logic       reset;
  logic       run;
  logic [8:0] ir;
  logic       gnz;
  logic [7:0] rOut;
  logic       gOut;
  logic       dinOut;
  logic [7:0] rIn;
  logic       irIn;
  logic       aIn;
  logic       gIn;
  logic       addSub;
  logic       done;
  out_t       act;

  int errors = 0;
  int checks = 0;

  vec_t vecs[$];
  out_t expQ[$];

  bus_control_unit dut (
    .Clock  (clock),
    .Reset  (reset),
    .Run    (run),
    .IR     (ir),
`ifdef CU_MVNZ_EN
    .GNZ    (gnz),
`endif
    .ROut   (rOut),
    .GOut   (gOut),
    .DINOut (dinOut),
    .RIn    (rIn),
    .IRIn   (irIn),
    .AIn    (aIn),
    .GIn    (gIn),
    .AddSub (addSub),
    .Done   (done)
  );

  assign act = {rOut, gOut, dinOut, rIn, irIn, aIn, gIn, addSub, done};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic out_t mkOut(logic [7:0] ro, logic go, logic dino, logic [7:0] ri,
                                 logic iri, logic ai, logic gi, logic as, logic dn);
    out_t o;
    o.rout = ro; o.gout = go; o.dinout = dino; o.rin = ri;
    o.irin = iri; o.ain = ai; o.gin = gi; o.addsub = as; o.done = dn;
    return o;
  endfunction

  // Cycle-by-cycle outputs an instruction produces after its fetch cycle
  function automatic void queueInstr(logic [8:0] instr, logic flag);
    logic [7:0] x;
    logic [7:0] y;
    x = 8'd1 << instr[5:3];
    y = 8'd1 << instr[2:0];
    case (instr[8:6])
      3'd0: expQ.push_back(mkOut(y, 0, 0, x, 0, 0, 0, 0, 1));
      3'd1: expQ.push_back(mkOut(0, 0, 1, x, 0, 0, 0, 0, 1));
      3'd2, 3'd3: begin
        expQ.push_back(mkOut(x, 0, 0, 0, 0, 1, 0, 0, 0));
        expQ.push_back(mkOut(y, 0, 0, 0, 0, 0, 1, instr[8:6] == 3'd3, 0));
        expQ.push_back(mkOut(0, 1, 0, x, 0, 0, 0, 0, 1));
      end
`ifdef CU_MVNZ_EN
      3'd4: expQ.push_back(flag ? mkOut(y, 0, 0, x, 0, 0, 0, 0, 1)
                                : mkOut(0, 0, 0, 0, 0, 0, 0, 0, 1));
`endif
      default: expQ.push_back(mkOut(0, 0, 0, 0, 0, 0, 0, 0, 1));
    endcase
  endfunction

  task automatic addVec(string name, logic r, logic rn, logic [8:0] instr, logic g, out_t e);
    vec_t v;
    v.name = name; v.rst = r; v.run = rn; v.ir = instr; v.gnz = g; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(logic r, logic rn, logic [8:0] instr, logic g);
    @(posedge clock);
    #1;
    reset = r;
    run   = rn;
    ir    = instr;
    gnz   = g;
    @(negedge clock);
  endtask

  task automatic checkOutput(string name, out_t e);
    int srcCount;
    logic anyLoad;
    checks++;
    if (act !== e) begin
      errors++;
      $display("[TB] FAIL %s: got %h (rout=%h rin=%h), required %h (rout=%h rin=%h)",
               name, act, act.rout, act.rin, e, e.rout, e.rin);
    end
    srcCount = $countones(rOut) + int'(gOut) + int'(dinOut);
    anyLoad  = (|rIn) | aIn | gIn;
    checks++;
    if (srcCount > 1 || (anyLoad && srcCount != 1)) begin
      errors++;
      $display("[TB] FAIL %s_onehot: got %0d bus sources with load=%0b, required exactly 1 when loading and at most 1",
               name, srcCount, anyLoad);
    end
  endtask

  out_t z;
  out_t mvnzExp;

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    ir    = '0;
    gnz   = 1'b0;
    z     = mkOut(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef CU_MVNZ_EN
    mvnzExp = mkOut(8'h02, 0, 0, 8'h01, 0, 0, 0, 0, 1);
`else
    mvnzExp = mkOut(0, 0, 0, 0, 0, 0, 0, 0, 1);
`endif

    addVec("reset0",     1, 1, 9'b000_010_101, 0, z);
    addVec("reset1",     1, 1, 9'b000_010_101, 0, z);
    addVec("mv_fetch",   0, 1, 9'b000_010_101, 0, mkOut(0, 0, 0, 0, 1, 0, 0, 0, 0));
    addVec("mv_t1",      0, 0, 9'b000_010_101, 0, mkOut(8'h20, 0, 0, 8'h04, 0, 0, 0, 0, 1));
    addVec("idle",       0, 0, 9'b000_010_101, 0, z);
    addVec("mvi_fetch",  0, 1, 9'b001_111_000, 0, mkOut(0, 0, 0, 0, 1, 0, 0, 0, 0));
    addVec("mvi_t1",     0, 1, 9'b001_111_000, 0, mkOut(0, 0, 1, 8'h80, 0, 0, 0, 0, 1));
    addVec("sub_fetch",  0, 1, 9'b011_001_011, 0, mkOut(0, 0, 0, 0, 1, 0, 0, 0, 0));
    addVec("sub_t1",     0, 1, 9'b011_001_011, 0, mkOut(8'h02, 0, 0, 0, 0, 1, 0, 0, 0));
    addVec("sub_t2",     0, 1, 9'b011_001_011, 0, mkOut(8'h08, 0, 0, 0, 0, 0, 1, 1, 0));
    addVec("sub_t3",     0, 0, 9'b011_001_011, 0, mkOut(0, 1, 0, 8'h02, 0, 0, 0, 0, 1));
    addVec("add_fetch",  0, 1, 9'b010_001_011, 0, mkOut(0, 0, 0, 0, 1, 0, 0, 0, 0));
    addVec("add_t1",     0, 0, 9'b010_001_011, 0, mkOut(8'h02, 0, 0, 0, 0, 1, 0, 0, 0));
    addVec("add_rst_t2", 1, 0, 9'b010_001_011, 0, z);
    addVec("add_abort",  0, 0, 9'b010_001_011, 0, z);
    addVec("mvrr_fetch", 0, 1, 9'b000_011_011, 0, mkOut(0, 0, 0, 0, 1, 0, 0, 0, 0));
    addVec("mvrr_t1",    0, 0, 9'b000_011_011, 0, mkOut(8'h08, 0, 0, 8'h08, 0, 0, 0, 0, 1));
    addVec("mvnz0_fch",  0, 1, 9'b100_000_001, 0, mkOut(0, 0, 0, 0, 1, 0, 0, 0, 0));
    addVec("mvnz0_t1",   0, 0, 9'b100_000_001, 0, mkOut(0, 0, 0, 0, 0, 0, 0, 0, 1));
    addVec("mvnz1_fch",  0, 1, 9'b100_000_001, 1, mkOut(0, 0, 0, 0, 1, 0, 0, 0, 0));
    addVec("mvnz1_t1",   0, 0, 9'b100_000_001, 1, mvnzExp);
    addVec("nop_fetch",  0, 1, 9'b111_101_010, 0, mkOut(0, 0, 0, 0, 1, 0, 0, 0, 0));
    addVec("nop_t1",     0, 0, 9'b111_101_010, 0, mkOut(0, 0, 0, 0, 0, 0, 0, 0, 1));
    addVec("idle_end",   0, 0, 9'b111_101_010, 0, z);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].run, vecs[i].ir, vecs[i].gnz);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // Random instruction streams; the DUT is idle in T0 after the table
    expQ.delete();
    for (int c = 0; c < 600; c++) begin
      logic       rRst;
      logic       rRun;
      logic [8:0] rIr;
      logic       rGnz;
      out_t       e;
      rRst = ($urandom_range(0, 39) == 0);
      rRun = 1'($urandom_range(0, 1));
      rIr  = ir;
      rGnz = gnz;
      if (expQ.size() == 0) begin
        rIr  = 9'($urandom);
        rGnz = 1'($urandom_range(0, 1));
      end
      if (rRst) begin
        e = z;
        expQ.delete();
      end else if (expQ.size() == 0) begin
        if (rRun) begin
          e = mkOut(0, 0, 0, 0, 1, 0, 0, 0, 0);
          queueInstr(rIr, rGnz);
        end else begin
          e = z;
        end
      end else begin
        e = expQ.pop_front();
      end
      applyStimulus(rRst, rRun, rIr, rGnz);
      checkOutput("random", e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
